// File: rtl/guess_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module     : guess_tracker_if
//  Description: Round-control bus between the game front end (start/board
//               and guess strobes) and the guess_tracker round controller.
//               master : drives start, board, guess_valid, guess_idx
//               slave  : drives show, ready, found, wrong_left, guess_ok,
//                        guess_bad, win, lose
//  Revision   : 1.0  initial release
// ============================================================================
interface guess_tracker_if #(
    parameter int CELLS     = 16,
    parameter int MAX_WRONG = 3,
    parameter int IDX_W     = $clog2(CELLS),
    parameter int WRONG_W   = $clog2(MAX_WRONG + 1)
);
    logic               start;
    logic [CELLS-1:0]   board;
    logic               guess_valid;
    logic [IDX_W-1:0]   guess_idx;
    logic               show;
    logic               ready;
    logic [CELLS-1:0]   found;
    logic [WRONG_W-1:0] wrong_left;
    logic               guess_ok;
    logic               guess_bad;
    logic               win;
    logic               lose;

    modport master (
        output start, board, guess_valid, guess_idx,
        input  show, ready, found, wrong_left, guess_ok, guess_bad, win, lose
    );

    modport slave (
        input  start, board, guess_valid, guess_idx,
        output show, ready, found, wrong_left, guess_ok, guess_bad, win, lose
    );
endinterface
`default_nettype wire

// File: rtl/guess_tracker.sv
`default_nettype none
// ============================================================================
//  Module     : guess_tracker
//  Description: Round controller for the memory-matrix game. Latches the
//               target board on start, shows it for SHOW_CYCLES clocks, then
//               classifies indexed cell guesses, tracking found cells and
//               remaining wrong guesses until the round is won or lost.
//  Ports      : clk    - system clock, rising edge
//               reset  - asynchronous, active-low reset
//               bus    - guess_tracker_if.slave (start/board/guess in,
//                        show/ready/found/wrong_left/pulses/win/lose out)
//  Option     : GUESS_TRACKER_DUP_PENALTY_EN - when defined, re-guessing an
//               already-found cell counts as a wrong guess; otherwise such a
//               repeat is silently ignored.
//  Revision   : 1.0  initial release
// ============================================================================
module guess_tracker #(
    parameter int CELLS       = 16,
    parameter int MAX_WRONG   = 3,
    parameter int SHOW_CYCLES = 100000000,
    parameter int IDX_W       = $clog2(CELLS),
    parameter int WRONG_W     = $clog2(MAX_WRONG + 1)
) (
    input  wire logic       clk,
    input  wire logic       reset,
    guess_tracker_if.slave  bus
);

    // A one-cycle show still needs a 1-bit counter.
    localparam int                  c_CNT_W      = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]  c_SHOW_LAST  = c_CNT_W'(SHOW_CYCLES - 1);
    localparam logic [WRONG_W-1:0]  c_WRONG_INIT = WRONG_W'(MAX_WRONG);
    localparam logic [CELLS-1:0]    c_CELL0      = CELLS'(1);

`ifdef GUESS_TRACKER_DUP_PENALTY_EN
    localparam logic c_DUP_PENALTY = 1'b1;
`else
    localparam logic c_DUP_PENALTY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SHOW = 3'd1,
        S_PLAY = 3'd2,
        S_WIN  = 3'd3,
        S_LOSE = 3'd4
    } state_t;

    state_t             r_state,      w_next_state;
    logic [CELLS-1:0]   r_target,     w_next_target;
    logic [CELLS-1:0]   r_found,      w_next_found;
    logic [WRONG_W-1:0] r_wrong_left, w_next_wrong_left;
    logic [c_CNT_W-1:0] r_show_cnt,   w_next_show_cnt;
    logic               r_guess_ok,   w_next_guess_ok;
    logic               r_guess_bad,  w_next_guess_bad;

    logic               w_idx_ok;
    logic [CELLS-1:0]   w_mask;
    logic               w_hit;
    logic               w_dup;

    // When CELLS fills the index space every index is legal; otherwise the
    // top codes are out of range and must be rejected.
    generate
        if (CELLS == (1 << IDX_W)) begin : g_range_full
            assign w_idx_ok = 1'b1;
        end else begin : g_range_part
            assign w_idx_ok = (bus.guess_idx < IDX_W'(CELLS));
        end
    endgenerate

    // One-hot cell mask; shift avoids out-of-bounds bit selects.
    assign w_mask = c_CELL0 << bus.guess_idx;
    assign w_hit  = |(r_target & w_mask);
    assign w_dup  = |(r_found  & w_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_target     <= '0;
            r_found      <= '0;
            r_wrong_left <= c_WRONG_INIT;
            r_show_cnt   <= '0;
            r_guess_ok   <= 1'b0;
            r_guess_bad  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_target     <= w_next_target;
            r_found      <= w_next_found;
            r_wrong_left <= w_next_wrong_left;
            r_show_cnt   <= w_next_show_cnt;
            r_guess_ok   <= w_next_guess_ok;
            r_guess_bad  <= w_next_guess_bad;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_target     = r_target;
        w_next_found      = r_found;
        w_next_wrong_left = r_wrong_left;
        w_next_show_cnt   = r_show_cnt;
        w_next_guess_ok   = 1'b0;
        w_next_guess_bad  = 1'b0;

        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.start) begin
                    w_next_target     = bus.board;
                    w_next_found      = '0;
                    w_next_wrong_left = c_WRONG_INIT;
                    w_next_show_cnt   = c_SHOW_LAST;
                    // An empty board is already solved.
                    w_next_state      = (bus.board == '0) ? S_WIN : S_SHOW;
                end
            end

            S_SHOW: begin
                if (r_show_cnt == '0) begin
                    w_next_state = S_PLAY;
                end else begin
                    w_next_show_cnt = r_show_cnt - 1'b1;
                end
            end

            S_PLAY: begin
                if (bus.guess_valid && w_idx_ok) begin
                    if (w_hit && !w_dup) begin
                        w_next_found    = r_found | w_mask;
                        w_next_guess_ok = 1'b1;
                        if ((r_found | w_mask) == r_target) begin
                            w_next_state = S_WIN;
                        end
                    end else if (!w_hit || c_DUP_PENALTY) begin
                        // wrong_left is >= 1 in PLAY: reaching 0 leaves PLAY.
                        w_next_wrong_left = r_wrong_left - 1'b1;
                        w_next_guess_bad  = 1'b1;
                        if (r_wrong_left == WRONG_W'(1)) begin
                            w_next_state = S_LOSE;
                        end
                    end
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.show       = (r_state == S_SHOW);
    assign bus.ready      = (r_state == S_PLAY);
    assign bus.win        = (r_state == S_WIN);
    assign bus.lose       = (r_state == S_LOSE);
    assign bus.found      = r_found;
    assign bus.wrong_left = r_wrong_left;
    assign bus.guess_ok   = r_guess_ok;
    assign bus.guess_bad  = r_guess_bad;

endmodule
`default_nettype wire

// File: tb/tb_guess_tracker.sv
`default_nettype none
// ============================================================================
//  Module     : tb_guess_tracker
//  Description: Self-checking bench for guess_tracker. A 16-cell instance is
//               exercised from a vector table; a 6-cell instance covers
//               out-of-range indices; hand sequences cover async reset.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_guess_tracker;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    guess_tracker_if #(.CELLS(16), .MAX_WRONG(3)) bus  ();
    guess_tracker_if #(.CELLS(6),  .MAX_WRONG(2)) bus2 ();

    guess_tracker #(.CELLS(16), .MAX_WRONG(3), .SHOW_CYCLES(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    guess_tracker #(.CELLS(6), .MAX_WRONG(2), .SHOW_CYCLES(1)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef GUESS_TRACKER_DUP_PENALTY_EN
    localparam logic       c_DUP_BAD = 1'b1;
    localparam logic [1:0] c_DUP_WL  = 2'd2;
`else
    localparam logic       c_DUP_BAD = 1'b0;
    localparam logic [1:0] c_DUP_WL  = 2'd3;
`endif

    typedef struct packed {
        logic        st;
        logic [15:0] board;
        logic        gv;
        logic [3:0]  gi;
        logic        e_show;
        logic        e_ready;
        logic [15:0] e_found;
        logic [1:0]  e_wl;
        logic        e_ok;
        logic        e_bad;
        logic        e_win;
        logic        e_lose;
    } vec_t;

    localparam int c_NVEC = 26;
    vec_t vecs [c_NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [15:0] b, input logic gv, input logic [3:0] gi);
        @(negedge clk);
        bus.start       = st;
        bus.board       = b;
        bus.guess_valid = gv;
        bus.guess_idx   = gi;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic st, input logic [5:0] b, input logic gv, input logic [2:0] gi);
        @(negedge clk);
        bus2.start       = st;
        bus2.board       = b;
        bus2.guess_valid = gv;
        bus2.guess_idx   = gi;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string p, input logic sh, input logic rd, input logic [15:0] fd,
                              input logic [1:0] wl, input logic ok, input logic bad,
                              input logic wn, input logic ls);
        check({p, ".show"},  32'(bus.show),       32'(sh));
        check({p, ".ready"}, 32'(bus.ready),      32'(rd));
        check({p, ".found"}, 32'(bus.found),      32'(fd));
        check({p, ".wl"},    32'(bus.wrong_left), 32'(wl));
        check({p, ".ok"},    32'(bus.guess_ok),   32'(ok));
        check({p, ".bad"},   32'(bus.guess_bad),  32'(bad));
        check({p, ".win"},   32'(bus.win),        32'(wn));
        check({p, ".lose"},  32'(bus.lose),       32'(ls));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            st  board     gv  gi   show rdy found     wl        ok  bad        win lose
        vecs[0]  = '{1'b1, 16'h0003, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b1, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 4'd0,  1'b0, 1'b1, 16'h0001, 2'd3,     1'b1, 1'b0,      1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 4'd0,  1'b0, 1'b1, 16'h0001, c_DUP_WL, 1'b0, c_DUP_BAD, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 4'd1,  1'b0, 1'b0, 16'h0003, c_DUP_WL, 1'b1, 1'b0,      1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0003, c_DUP_WL, 1'b0, 1'b0,      1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h0001, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b1, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[14] = '{1'b1, 16'hFFFF, 1'b0, 4'd0,  1'b0, 1'b1, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 4'd5,  1'b0, 1'b1, 16'h0000, 2'd2,     1'b0, 1'b1,      1'b0, 1'b0};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 4'd6,  1'b0, 1'b1, 16'h0000, 2'd1,     1'b0, 1'b1,      1'b0, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b1, 4'd7,  1'b0, 1'b0, 16'h0000, 2'd0,     1'b0, 1'b1,      1'b0, 1'b1};
        vecs[18] = '{1'b0, 16'h0000, 1'b1, 4'd0,  1'b0, 1'b0, 16'h0000, 2'd0,     1'b0, 1'b0,      1'b0, 1'b1};
        vecs[19] = '{1'b1, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b1, 1'b0};
        vecs[20] = '{1'b1, 16'h8000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[21] = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[22] = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[23] = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[24] = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b1, 16'h0000, 2'd3,     1'b0, 1'b0,      1'b0, 1'b0};
        vecs[25] = '{1'b0, 16'h0000, 1'b1, 4'd15, 1'b0, 1'b0, 16'h8000, 2'd3,     1'b1, 1'b0,      1'b1, 1'b0};

        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.board        = '0;
        bus.guess_valid  = 1'b0;
        bus.guess_idx    = '0;
        bus2.start       = 1'b0;
        bus2.board       = '0;
        bus2.guess_valid = 1'b0;
        bus2.guess_idx   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_main("rst", 1'b0, 1'b0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_main("idle", 1'b0, 1'b0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].st, vecs[i].board, vecs[i].gv, vecs[i].gi);
            check_main($sformatf("v%0d", i), vecs[i].e_show, vecs[i].e_ready, vecs[i].e_found,
                       vecs[i].e_wl, vecs[i].e_ok, vecs[i].e_bad, vecs[i].e_win, vecs[i].e_lose);
        end

        // Asynchronous reset in the middle of PLAY with one cell found.
        drive(1'b1, 16'h0003, 1'b0, 4'd0);
        repeat (4) drive(1'b0, 16'h0000, 1'b0, 4'd0);
        check("arst.ready_pre", 32'(bus.ready), 32'd1);
        drive(1'b0, 16'h0000, 1'b1, 4'd0);
        check("arst.found_pre", 32'(bus.found), 32'h0001);
        #2;
        reset = 1'b0;
        #1;
        check_main("arst", 1'b0, 1'b0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.guess_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_main("arst.post", 1'b0, 1'b0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Out-of-range indices on a 6-cell board (indices 6 and 7 do not exist).
        drive2(1'b1, 6'b000001, 1'b0, 3'd0);
        check("oor.show",   32'(bus2.show), 32'd1);
        drive2(1'b0, 6'b000000, 1'b0, 3'd0);
        check("oor.ready",  32'(bus2.ready), 32'd1);
        drive2(1'b0, 6'b000000, 1'b1, 3'd6);
        check("oor6.ok",    32'(bus2.guess_ok),   32'd0);
        check("oor6.bad",   32'(bus2.guess_bad),  32'd0);
        check("oor6.wl",    32'(bus2.wrong_left), 32'd2);
        drive2(1'b0, 6'b000000, 1'b1, 3'd7);
        check("oor7.bad",   32'(bus2.guess_bad),  32'd0);
        check("oor7.wl",    32'(bus2.wrong_left), 32'd2);
        check("oor7.ready", 32'(bus2.ready),      32'd1);
        drive2(1'b0, 6'b000000, 1'b1, 3'd3);
        check("miss3.bad",  32'(bus2.guess_bad),  32'd1);
        check("miss3.wl",   32'(bus2.wrong_left), 32'd1);
        drive2(1'b0, 6'b000000, 1'b1, 3'd0);
        check("hit0.ok",    32'(bus2.guess_ok),   32'd1);
        check("hit0.found", 32'(bus2.found),      32'h01);
        check("hit0.win",   32'(bus2.win),        32'd1);
        drive2(1'b0, 6'b000000, 1'b0, 3'd0);
        check("hit0.okclr", 32'(bus2.guess_ok),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
